uart_cmd_ctrl: RTL and testbench

Host-command sequencer between the UART byte receiver/transmitter and the core's MMIO command mailbox.
- Collects one opcode byte plus a 32-bit little-endian argument from the UART RX byte stream.
- Hands the command to the core with a valid/ready handshake.
- Collects RSP_WORDS 32-bit response words from the core and serializes them LSB-first onto UART TX.
- Sits beside the UART in riscv_top; this is the host protocol for benchmark runs (e.g. op 0/1 with array length, returning cycle counts).

---
 rtl/uart_cmd_ctrl.sv | 179 +++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// Host command sequencer: UART RX frame (opcode + 32-bit LE argument) -> core mailbox -> LSB-first UART TX response.
// Optional inter-byte receive timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl #(
  parameter int NUM_OPS     = 8,
  parameter int RSP_WORDS   = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [7:0]  cmd_op,
  output logic [31:0] cmd_arg,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic [31:0] rsp_data,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  output logic        busy,
  output logic        err,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, GET_ARG, ISSUE, WAIT_RSP, SEND, DRAIN} state_t;

  localparam logic [8:0] OP_LIMIT  = 9'(NUM_OPS);
  localparam logic [3:0] LAST_WORD = 4'(RSP_WORDS - 1);

  state_t      state;
  logic [1:0]  byte_cnt;  // argument byte in GET_ARG, response byte in SEND
  logic [3:0]  word_cnt;
  logic [31:0] shift;
  logic        guard;
  logic        tx_free;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_cnt;
`endif

  // NOTE: tx_busy only rises the cycle after tx_start, so the guard masks that stale low cycle.
  assign tx_free = !tx_busy && !guard;

  // NOTE: all state is updated with non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      byte_cnt  <= 2'd0;
      word_cnt  <= 4'd0;
      shift     <= 32'd0;
      guard     <= 1'b0;
      tx_data   <= 8'd0;
      tx_start  <= 1'b0;
      cmd_op    <= 8'd0;
      cmd_arg   <= 32'd0;
      cmd_valid <= 1'b0;
      rsp_ready <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      tx_start <= 1'b0;
      err      <= 1'b0;
      guard    <= 1'b0;

      if (rx_valid && state != IDLE && state != GET_ARG)
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (rx_valid) begin
            cmd_op   <= rx_data;
            byte_cnt <= 2'd0;
            busy     <= 1'b1;
            state    <= GET_ARG;
`ifdef UART_CMD_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end
        end

        GET_ARG: begin
          if (rx_valid) begin
            cmd_arg[8*byte_cnt +: 8] <= rx_data;
            byte_cnt <= byte_cnt + 2'd1;
`ifdef UART_CMD_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
            if (byte_cnt == 2'd3) begin
              if ({1'b0, cmd_op} < OP_LIMIT) begin
                cmd_valid <= 1'b1;
                state     <= ISSUE;
              end else begin
                err   <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end
`ifdef UART_CMD_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end

        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            word_cnt  <= 4'd0;
            rsp_ready <= 1'b1;
            state     <= WAIT_RSP;
          end
        end

        WAIT_RSP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_ready <= 1'b0;
            state     <= SEND;
            // Start byte 0 straight from the bus when the transmitter is free.
            if (tx_free) begin
              tx_start <= 1'b1;
              tx_data  <= rsp_data[7:0];
              shift    <= {8'h00, rsp_data[31:8]};
              guard    <= 1'b1;
              byte_cnt <= 2'd1;
            end else begin
              shift    <= rsp_data;
              byte_cnt <= 2'd0;
            end
          end
        end

        SEND: begin
          if (tx_free) begin
            tx_start <= 1'b1;
            tx_data  <= shift[7:0];
            shift    <= {8'h00, shift[31:8]};
            guard    <= 1'b1;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (word_cnt == LAST_WORD) begin
                state <= DRAIN;
              end else begin
                word_cnt  <= word_cnt + 4'd1;
                rsp_ready <= 1'b1;
                state     <= WAIT_RSP;
              end
            end
          end
        end

        DRAIN: begin
          if (tx_free) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus pushes expected commands/TX bytes, a negedge monitor pops and compares.
module tb_uart_cmd_ctrl;

  localparam int NUM_OPS     = 8;
  localparam int RSP_WORDS   = 2;
  localparam int TIMEOUT_CYC = 50;
  localparam int TX_CYCLES   = 10;

  logic        clk = 1'b0;
  logic        Rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        busy;
  logic        err;
  logic        overrun;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .NUM_OPS    (NUM_OPS),
    .RSP_WORDS  (RSP_WORDS),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .Rst      (Rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .cmd_op   (cmd_op),
    .cmd_arg  (cmd_arg),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .rsp_data (rsp_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .busy     (busy),
    .err      (err),
    .overrun  (overrun)
  );

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] arg;
  } cmd_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  cmd_t       exp_cmd[$];
  logic [7:0] exp_tx[$];
  int         err_pulses = 0;
  int         exp_err    = 0;
  int         tx_count   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor: compares handshakes and TX bytes against the scoreboard queues.
  logic prev_busy  = 1'b0;
  logic prev_start = 1'b0;
  initial forever begin
    cmd_t e;
    @(negedge clk);
    if (!Rst) begin
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          fail("cmd_handshake", "got a command, expected none");
        end else begin
          e = exp_cmd.pop_front();
          check("cmd_op_at_handshake", 32'(cmd_op), 32'(e.op));
          check("cmd_arg_at_handshake", cmd_arg, e.arg);
        end
      end
      if (tx_start) begin
        tx_count++;
        check("tx_start_while_busy", 32'(prev_busy), 32'd0);
        check("tx_start_spacing", 32'(prev_start), 32'd0);
        if (exp_tx.size() == 0) fail("tx_byte", $sformatf("got 0x%0h, expected no byte", tx_data));
        else check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
      if (err) err_pulses++;
    end
    prev_busy  = tx_busy;
    prev_start = tx_start;
  end

  // Transmitter model: busy from the cycle after tx_start for TX_CYCLES cycles.
  int   busy_left  = 0;
  logic start_seen = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end
    if (start_seen) begin
      tx_busy   = 1'b1;
      busy_left = TX_CYCLES;
    end
    start_seen = tx_start;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] arg);
    send_byte(op);
    for (int k = 0; k < 4; k++) send_byte(arg[8*k +: 8]);
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_cmd_op"}, 32'(cmd_op), 32'd0);
    check({tag, "_cmd_arg"}, cmd_arg, 32'd0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_rsp_ready"}, 32'(rsp_ready), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  // Called right after the last argument byte; holds cmd_ready low for 'hold' cycles.
  task automatic accept_cmd(input logic [7:0] op, input logic [31:0] arg, input int hold);
    check("cmd_valid_latency", 32'(cmd_valid), 32'd1);
    check("cmd_op", 32'(cmd_op), 32'(op));
    check("cmd_arg", cmd_arg, arg);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("cmd_valid_held", 32'(cmd_valid), 32'd1);
      check("cmd_arg_held", cmd_arg, arg);
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("cmd_valid_dropped", 32'(cmd_valid), 32'd0);
    check("rsp_ready_raised", 32'(rsp_ready), 32'd1);
  endtask

  task automatic give_rsp(input logic [31:0] w, input bit chk_latency);
    bit done = 1'b0;
    for (int k = 0; k < 4; k++) exp_tx.push_back(w[8*k +: 8]);
    rsp_data  = w;
    rsp_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      if (rsp_ready) done = 1'b1;
      tick();
    end
    rsp_valid = 1'b0;
    if (!done) begin
      fail("rsp_accept", "rsp_ready never rose, expected it within 200 cycles");
    end else begin
      check("rsp_ready_dropped", 32'(rsp_ready), 32'd0);
      if (chk_latency) check("rsp_to_tx_start", 32'(tx_start), 32'd1);
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      if (!busy) done = 1'b1;
      else tick();
    end
    if (!done) fail("busy_return", "busy stuck high, expected 0 within 400 cycles");
    else check("idle_after_stop_bit", 32'(tx_busy), 32'd0);
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [31:0] arg,
                         input logic [31:0] w0, input logic [31:0] w1);
    exp_cmd.push_back({op, arg});
    send_frame(op, arg);
    accept_cmd(op, arg, 0);
    give_rsp(w0, 1'b1);
    give_rsp(w1, 1'b0);
    wait_idle();
  endtask

  task automatic reject_frame(input logic [7:0] op, input logic [31:0] arg);
    send_frame(op, arg);
    exp_err++;
    check("reject_err_pulse", 32'(err), 32'd1);
    check("reject_no_cmd_valid", 32'(cmd_valid), 32'd0);
    check("reject_idle", 32'(busy), 32'd0);
    tick();
    check("reject_err_one_cycle", 32'(err), 32'd0);
  endtask

  initial begin
    int waited;
    Rst       = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    tx_busy   = 1'b0;
    cmd_ready = 1'b0;
    rsp_data  = 32'h0;
    rsp_valid = 1'b0;
    tick(3);
    outputs_zero("reset");
    Rst = 1'b0;
    tick(2);

    // Accepted command with a stalled handshake, two response words, overrun during SEND.
    exp_cmd.push_back({8'h00, 32'h0000_0100});
    send_frame(8'h00, 32'h0000_0100);
    accept_cmd(8'h00, 32'h0000_0100, 5);
    give_rsp(32'h1234_5678, 1'b1);
    check("overrun_before", 32'(overrun), 32'd0);
    send_byte(8'h55);
    check("overrun_in_send", 32'(overrun), 32'd1);
    give_rsp(32'h9ABC_DEF0, 1'b0);
    wait_idle();
    check("tx_bytes_first_cmd", 32'(tx_count), 32'd8);

    // Rejected opcodes still consume four argument bytes.
    reject_frame(8'h09, 32'hDEAD_BEEF);
    reject_frame(8'h08, 32'h0102_0304);
    run_cmd(8'h01, 32'h0000_0100, 32'hA1B2_C3D4, 32'h0000_0001);
    check("overrun_sticky", 32'(overrun), 32'd1);
    run_cmd(8'h07, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0055_AA00);

    // Asynchronous reset in mid-frame.
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2;
    Rst = 1'b1;
    #1;
    outputs_zero("async_reset");
    tick();
    Rst = 1'b0;
    tick(2);
    run_cmd(8'h01, 32'h0000_00FF, 32'hCAFE_F00D, 32'h00C0_FFEE);

`ifdef UART_CMD_TIMEOUT_EN
    send_byte(8'h02);
    send_byte(8'h11);
    waited = 0;
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (err && waited == 0) waited = t;
    end
    exp_err++;
    check("timeout_cycles", 32'(waited), 32'(TIMEOUT_CYC));
    check("timeout_idle", 32'(busy), 32'd0);
    run_cmd(8'h03, 32'h0403_0201, 32'h1111_2222, 32'h3333_4444);
`endif

    tick(5);
    check("err_pulse_count", 32'(err_pulses), 32'(exp_err));
    check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    check("cmd_queue_drained", 32'(exp_cmd.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
